// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the unified RAM and mem_arbiter.
// The arbiter uses the slave modport; requesters and the RAM side use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic [31:0]       ram_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_be, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, ram_be, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_be, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, ram_be, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the unified single-port RAM shared by IF and MEM.
// Define ARB_FAIR_EN for round-robin on ties; default is fixed MEM-over-IF priority.
module mem_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  // state  | meaning
  // IDLE   | sample requests, grant and latch the winner
  // ACCESS | single ram_en strobe from the latched request
  // WAIT   | count out RAM latency, capture read data on terminal count
  // RESP   | one-cycle ready pulse to the owner
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic              owner_mem;
  logic              wr_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [3:0]        cnt;
  logic [31:0]       if_rdata_q;
  logic [31:0]       mem_rdata_q;

  logic mem_req;
  logic grant_any;
  logic grant_mem;

  assign mem_req   = bus.mem_rd | bus.mem_wr;
  assign grant_any = mem_req | bus.if_req;

`ifdef ARB_FAIR_EN
  logic last_mem;

  // On a tie the requester that did not win last time gets the RAM.
  assign grant_mem = mem_req & (~bus.if_req | ~last_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem <= 1'b0;
    end else if (state == S_IDLE && grant_any) begin
      last_mem <= grant_mem;
    end
  end
`else
  assign grant_mem = mem_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant_any) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_WAIT;
      S_WAIT:   if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ram_en    = (state == S_ACCESS);
    bus.ram_we    = (state == S_ACCESS) & wr_q;
    bus.if_ready  = (state == S_RESP) & ~owner_mem;
    bus.mem_ready = (state == S_RESP) & owner_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      cnt         <= 4'd0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner_mem <= grant_mem;
            if (grant_mem) begin
              addr_q  <= bus.mem_addr[ADDR_W-1:2];
              wr_q    <= bus.mem_wr;
              wdata_q <= bus.mem_wdata;
              be_q    <= bus.mem_wr ? bus.mem_be : 4'b1111;
            end else begin
              addr_q  <= bus.if_addr[ADDR_W-1:2];
              wr_q    <= 1'b0;
              be_q    <= 4'b1111;
            end
          end
        end
        S_ACCESS: cnt <= 4'(WAIT_STATES - 1);
        S_WAIT: begin
          if (cnt == 4'd0) begin
            if (!wr_q) begin
              if (owner_mem) mem_rdata_q <= bus.ram_rdata;
              else           if_rdata_q  <= bus.ram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_be    = be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = mem_req & ~bus.mem_ready;

  // Byte-offset bits never reach the word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_STATES=1 vector table plus reset,
// arbitration and WAIT_STATES=3 sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32)) b3 ();

  mem_arbiter #(.WAIT_STATES(1), .ADDR_W(32)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.WAIT_STATES(3), .ADDR_W(32)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  logic [31:0] ram1 [64];
  logic [31:0] ram3 [64];

  always @(posedge clk) begin
    if (b1.ram_en && b1.ram_we)
      for (int k = 0; k < 4; k++)
        if (b1.ram_be[k]) ram1[b1.ram_addr[5:0]][8*k +: 8] <= b1.ram_wdata[8*k +: 8];
    if (b3.ram_en && b3.ram_we)
      for (int k = 0; k < 4; k++)
        if (b3.ram_be[k]) ram3[b3.ram_addr[5:0]][8*k +: 8] <= b3.ram_wdata[8*k +: 8];
  end

  assign b1.ram_rdata = ram1[b1.ram_addr[5:0]];
  assign b3.ram_rdata = ram3[b3.ram_addr[5:0]];

  typedef struct {
    logic        is_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [29:0] exp_ram_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_b1();
    b1.if_req = 1'b0; b1.mem_rd = 1'b0; b1.mem_wr = 1'b0;
  endtask

  // One transaction on the WAIT_STATES=1 instance; FSM must be idle on entry.
  task automatic run_vec(input vec_t v, input string tag);
    int  cyc;
    int  en_cnt;
    bit  done;
    @(negedge clk);
    if (v.is_if) begin
      b1.if_req  = 1'b1;
      b1.if_addr = v.addr;
    end else begin
      b1.mem_rd    = v.rd;
      b1.mem_wr    = v.wr;
      b1.mem_addr  = v.addr;
      b1.mem_wdata = v.wdata;
      b1.mem_be    = v.be;
    end
    #1;
    chk({tag, " stall@0"}, v.is_if ? b1.stall_if : b1.stall_mem, 1);
    cyc = 0; en_cnt = 0; done = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (b1.ram_en) en_cnt++;
      if (cyc == 1) begin
        chk({tag, " ram_en"},   b1.ram_en, 1);
        chk({tag, " ram_we"},   b1.ram_we, v.exp_we);
        chk({tag, " ram_addr"}, b1.ram_addr, v.exp_ram_addr);
        chk({tag, " ram_be"},   b1.ram_be, v.exp_be);
        if (v.exp_we) chk({tag, " ram_wdata"}, b1.ram_wdata, v.wdata);
      end
      if (b1.if_ready || b1.mem_ready) done = 1;
    end
    chk({tag, " latency"},   cyc, 3);
    chk({tag, " en_cycles"}, en_cnt, 1);
    chk({tag, " if_ready"},  b1.if_ready, v.is_if);
    chk({tag, " mem_ready"}, b1.mem_ready, !v.is_if);
    chk({tag, " if_rdata"},  b1.if_rdata, v.exp_if_rdata);
    chk({tag, " mem_rdata"}, b1.mem_rdata, v.exp_mem_rdata);
    clear_b1();
    #1;
    chk({tag, " stall_done"}, v.is_if ? b1.stall_if : b1.stall_mem, 0);
    @(negedge clk);
    chk({tag, " ready_pulse"}, b1.if_ready | b1.mem_ready, 0);
  endtask

  vec_t vecs [7];
  vec_t fresh;
  int   order [4];
  int   exp_order [4];

  initial begin
    int ng, if_left, mem_left, cyc, en_cnt, pulses;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 30'd4,         1'b0, 4'hF, 32'h00A00093, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'hDEADBEEF,  4'h3, 30'd8,         1'b1, 4'h3, 32'h00A00093, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 30'd8,         1'b0, 4'hF, 32'h00A00093, 32'h1122BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0024, 32'hCAFEF00D,  4'hF, 30'd9,         1'b1, 4'hF, 32'h00A00093, 32'h1122BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'h0, 30'd9,         1'b0, 4'hF, 32'hCAFEF00D, 32'h1122BEEF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h3, 30'd4,         1'b0, 4'hF, 32'hCAFEF00D, 32'h00A00093};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 30'h3FFFFFFF,  1'b0, 4'hF, 32'h13579BDF, 32'h00A00093};

    for (int i = 0; i < 64; i++) begin
      ram1[i] = 32'h0;
      ram3[i] = 32'h0;
    end
    ram1[4]  = 32'h00A00093;
    ram1[8]  = 32'h11223344;
    ram1[63] = 32'h13579BDF;
    ram3[2]  = 32'hA5A50002;

    clear_b1();
    b1.if_addr = '0; b1.mem_addr = '0; b1.mem_wdata = '0; b1.mem_be = '0;
    b3.if_req = 1'b0; b3.mem_rd = 1'b0; b3.mem_wr = 1'b0;
    b3.if_addr = '0; b3.mem_addr = '0; b3.mem_wdata = '0; b3.mem_be = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ram_en",    b1.ram_en, 0);
    chk("reset ram_be",    b1.ram_be, 0);
    chk("reset ram_addr",  b1.ram_addr, 0);
    chk("reset if_rdata",  b1.if_rdata, 0);
    chk("reset ready",     b1.if_ready | b1.mem_ready, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the IF read sits in WAIT: no ready, everything back to reset values.
    @(negedge clk);
    b1.if_req = 1'b1; b1.if_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    b1.if_req = 1'b0;
    @(negedge clk);
    chk("rst ram_en",    b1.ram_en, 0);
    chk("rst ram_we",    b1.ram_we, 0);
    chk("rst ready",     b1.if_ready | b1.mem_ready, 0);
    chk("rst ram_addr",  b1.ram_addr, 0);
    chk("rst ram_be",    b1.ram_be, 0);
    chk("rst ram_wdata", b1.ram_wdata, 0);
    chk("rst if_rdata",  b1.if_rdata, 0);
    chk("rst mem_rdata", b1.mem_rdata, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (b1.if_ready || b1.mem_ready) pulses++;
    end
    chk("rst no_ready", pulses, 0);
    fresh = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 30'd4, 1'b0, 4'hF, 32'h00A00093, 32'h0};
    run_vec(fresh, "post_rst");

    // Both requesters pending, two requests each; record owner of each response.
    @(negedge clk);
    b1.if_req = 1'b1; b1.if_addr = 32'h10;
    b1.mem_rd = 1'b1; b1.mem_addr = 32'h20;
    if_left = 2; mem_left = 2; ng = 0; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (b1.mem_ready) begin
        order[ng] = 1; ng++; mem_left--;
        if (mem_left == 0) b1.mem_rd = 1'b0;
      end
      if (b1.if_ready) begin
        order[ng] = 0; ng++; if_left--;
        if (if_left == 0) b1.if_req = 1'b0;
      end
    end
    clear_b1();
    chk("arb responses", ng, 4);
`ifdef ARB_FAIR_EN
    exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
`else
    exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 0;
`endif
    for (int i = 0; i < ng; i++) chk($sformatf("arb grant%0d is_mem", i), order[i], exp_order[i]);

    // WAIT_STATES=3 load, request dropped early: still completes in 5 cycles.
    @(negedge clk);
    b3.mem_rd = 1'b1; b3.mem_addr = 32'h8;
    cyc = 0; en_cnt = 0;
    while (cyc < 20 && !b3.mem_ready) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (b3.ram_en) en_cnt++;
      if (cyc == 1) chk("ws3 ram_addr", b3.ram_addr, 2);
      if (cyc == 2) b3.mem_rd = 1'b0;
    end
    chk("ws3 latency",   cyc, 5);
    chk("ws3 en_cycles", en_cnt, 1);
    chk("ws3 mem_rdata", b3.mem_rdata, 32'hA5A50002);
    chk("ws3 if_ready",  b3.if_ready, 0);
    @(negedge clk);
    chk("ws3 ready_pulse", b3.mem_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
